// File: rtl/csa_resolve_acc.sv
// Carry-save accumulator for weight-aligned (1/2/4) redundant beats, resolved chunk-by-chunk to binary.
// Optional saturation of the result on overflow: define CSA_RESOLVE_SAT_EN.
module csa_resolve_acc #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [IN_W-1:0]  in_sum,
   input  logic [IN_W-1:0]  in_carry,
   input  logic [IN_W-1:0]  in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);

   // state      | meaning
   // ST_ACCUM   | accepting beats, folding them into the carry-save pair
   // ST_RESOLVE | N cycles of chunked carry-propagate, LSB chunk first
   // ST_OUTPUT  | result presented, waiting for out_ready
   localparam logic [1:0] ST_ACCUM   = 2'd0;
   localparam logic [1:0] ST_RESOLVE = 2'd1;
   localparam logic [1:0] ST_OUTPUT  = 2'd2;

   localparam int N  = ACC_W / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [1:0]       state_q;
   logic [ACC_W-1:0] s_q, c_q, data_q;
   logic             ovf_q, ovf_out_q, cy_q;
   logic [CW-1:0]    cnt_q;

   logic [ACC_W-1:0] z1, z2, z4;
   logic [ACC_W-1:0] s1, s2, s3, m1, m2, m3, c1, c2, c3;
   logic             drop;
   logic [CHUNK:0]   csum;
   logic [ACC_W-1:0] s_res_next, c_res_next, data_fin;
   logic             ovf_fin;

   assign z1 = {{(ACC_W-IN_W){1'b0}}, in_sum};
   assign z2 = {{(ACC_W-IN_W-1){1'b0}}, in_carry, 1'b0};
   assign z4 = {{(ACC_W-IN_W-2){1'b0}}, in_cout, 2'b00};

   // Three chained 3:2 stages reduce {s, c, z1, z2, z4} back to two vectors.
   // A majority bit at the MSB has weight 2^ACC_W, so it can only mean overflow.
   always_comb begin
      s1 = s_q ^ c_q ^ z1;
      m1 = (s_q & c_q) | (s_q & z1) | (c_q & z1);
      c1 = {m1[ACC_W-2:0], 1'b0};
      s2 = s1 ^ c1 ^ z2;
      m2 = (s1 & c1) | (s1 & z2) | (c1 & z2);
      c2 = {m2[ACC_W-2:0], 1'b0};
      s3 = s2 ^ c2 ^ z4;
      m3 = (s2 & c2) | (s2 & z4) | (c2 & z4);
      c3 = {m3[ACC_W-2:0], 1'b0};
      drop = m1[ACC_W-1] | m2[ACC_W-1] | m3[ACC_W-1];
   end

   // Resolved chunks enter s_q from the top while both vectors shift right,
   // so after N cycles s_q is the binary result and c_q is zero.
   always_comb begin
      csum       = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
      s_res_next = {csum[CHUNK-1:0], s_q[ACC_W-1:CHUNK]};
      c_res_next = c_q >> CHUNK;
      ovf_fin    = ovf_q | csum[CHUNK];
`ifdef CSA_RESOLVE_SAT_EN
      data_fin   = ovf_fin ? {ACC_W{1'b1}} : s_res_next;
`else
      data_fin   = s_res_next;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ACCUM;
         s_q       <= '0;
         c_q       <= '0;
         data_q    <= '0;
         ovf_q     <= 1'b0;
         ovf_out_q <= 1'b0;
         cy_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (in_valid) begin
                  s_q   <= s3;
                  c_q   <= c3;
                  ovf_q <= ovf_q | drop;
                  if (in_last) begin
                     state_q <= ST_RESOLVE;
                     cnt_q   <= CW'(N-1);
                     cy_q    <= 1'b0;
                  end
               end
            end
            ST_RESOLVE: begin
               s_q   <= s_res_next;
               c_q   <= c_res_next;
               cy_q  <= csum[CHUNK];
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q   <= ST_OUTPUT;
                  data_q    <= data_fin;
                  ovf_out_q <= ovf_fin;
                  cy_q      <= 1'b0;
               end
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  state_q <= ST_ACCUM;
                  s_q     <= '0;
                  c_q     <= '0;
                  ovf_q   <= 1'b0;
               end
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_OUTPUT);
   assign out_data  = data_q;
   assign out_ovf   = ovf_out_q;

endmodule

// File: tb/tb_csa_resolve_acc.sv
// Directed bench for csa_resolve_acc: default 32/8 instance plus a 20-bit/4-bit instance for overflow.
module tb_csa_resolve_acc;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_last, out_ready;
   logic [15:0] in_sum, in_carry, in_cout;
   logic        in_ready, out_valid, out_ovf;
   logic [31:0] out_data;

   logic        v20, l20, ordy20;
   logic [15:0] s20, c20, k20;
   logic        rdy20, ov20, ovf20;
   logic [19:0] d20;

   int tests = 0;
   int fails = 0;

   csa_resolve_acc dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_sum(in_sum), .in_carry(in_carry), .in_cout(in_cout), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
   );

   csa_resolve_acc #(.IN_W(16), .ACC_W(20), .CHUNK(4)) dut20 (
      .clk(clk), .rst_n(rst_n), .in_valid(v20), .in_ready(rdy20), .in_last(l20),
      .in_sum(s20), .in_carry(c20), .in_cout(k20), .out_valid(ov20),
      .out_ready(ordy20), .out_data(d20), .out_ovf(ovf20)
   );

   // Drives one output handshake on the default instance (no checking).
   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   // Waits (bounded) until out_valid is seen on a falling edge; ok=0 on timeout.
   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      in_valid = 0; in_last = 0; in_sum = 0; in_carry = 0; in_cout = 0; out_ready = 0;
      v20 = 0; l20 = 0; s20 = 0; c20 = 0; k20 = 0; ordy20 = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({in_ready, out_valid, out_ovf, out_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
         fails++;
         $display("FAIL reset: ready=%0b valid=%0b ovf=%0b data=%0d, required 1 0 0 0",
                  in_ready, out_valid, out_ovf, out_data);
      end
   endtask

   task automatic test_single_beat();
      in_valid = 1; in_last = 1; in_sum = 16'h0003; in_carry = 16'h0001; in_cout = 16'h0001;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL single_ready: in_ready=%0b, required 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 0; in_last = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== (i == 5) || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_latency cycle %0d: valid=%0b ready=%0b, required valid=%0b ready=0",
                     i, out_valid, in_ready, (i == 5));
         end
      end
      tests++;
      if (out_data !== 32'd9 || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL single_data: data=%0d ovf=%0b, required 9 0", out_data, out_ovf);
      end
      handshake();
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd9) begin
         fails++;
         $display("FAIL single_after_hs: ready=%0b valid=%0b data=%0d, required 1 0 9",
                  in_ready, out_valid, out_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] sv [3] = '{16'd1, 16'd0, 16'd0};
      logic [15:0] cv [3] = '{16'd0, 16'd1, 16'd0};
      logic [15:0] kv [3] = '{16'd0, 16'd0, 16'hFFFF};
      for (int b = 0; b < 3; b++) begin
         in_valid = 1; in_last = (b == 2); in_sum = sv[b]; in_carry = cv[b]; in_cout = kv[b];
         tests++;
         if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready beat %0d: in_ready=%0b, required 1", b, in_ready);
         end
         @(posedge clk);
         #1;
         @(negedge clk);
      end
      in_valid = 0; in_last = 0;
      // The loop above already consumed the first post-accept falling edge.
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_resolve cycle 1: ready=%0b valid=%0b, required 0 0", in_ready, out_valid);
      end
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_resolve cycle %0d: ready=%0b valid=%0b, required 0 0",
                     i, in_ready, out_valid);
         end
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'd262143 || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL b2b_data: valid=%0b data=%0d ovf=%0b, required 1 262143 0",
                  out_valid, out_data, out_ovf);
      end
      handshake();
   endtask

   task automatic test_overflow();
      bit ok;
      logic [19:0] exp;
`ifdef CSA_RESOLVE_SAT_EN
      exp = 20'hFFFFF;
`else
      exp = 20'd196573;
`endif
      @(negedge clk);
      for (int b = 0; b < 5; b++) begin
         v20 = 1; l20 = (b == 4); s20 = 16'hFFFF; c20 = 16'hFFFF; k20 = 16'hFFFF;
         @(posedge clk);
         #1;
      end
      v20 = 0; l20 = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ov20 === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL ovf_timeout: out_valid=%0b, required 1 within 20 cycles", ov20);
      end
      tests++;
      if (d20 !== exp || ovf20 !== 1'b1) begin
         fails++;
         $display("FAIL ovf_data: data=%0d ovf=%0b, required %0d 1", d20, ovf20, exp);
      end
      ordy20 = 1;
      @(posedge clk);
      #1 ordy20 = 0;
      // Follow-up group must start with a clean overflow flag.
      v20 = 1; l20 = 1; s20 = 16'd1; c20 = 0; k20 = 0;
      @(posedge clk);
      #1 v20 = 0; l20 = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ov20 === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok || d20 !== 20'd1 || ovf20 !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear: valid=%0b data=%0d ovf=%0b, required 1 1 0", ok, d20, ovf20);
      end
      ordy20 = 1;
      @(posedge clk);
      #1 ordy20 = 0;
   endtask

   task automatic test_backpressure();
      bit ok;
      @(negedge clk);
      in_valid = 1; in_last = 1; in_sum = 16'hFFFF; in_carry = 16'hFFFF; in_cout = 16'hFFFF;
      @(posedge clk);
      #1 in_valid = 0; in_last = 0;
      wait_valid(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL bp_timeout: out_valid=%0b, required 1", out_valid);
      end
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || out_data !== 32'd458745 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold cycle %0d: valid=%0b data=%0d ovf=%0b ready=%0b, required 1 458745 0 0",
                     i, out_valid, out_data, out_ovf, in_ready);
         end
      end
      handshake();
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd458745) begin
         fails++;
         $display("FAIL bp_release: ready=%0b valid=%0b data=%0d, required 1 0 458745",
                  in_ready, out_valid, out_data);
      end
      in_valid = 1; in_last = 1; in_sum = 16'd2; in_carry = 0; in_cout = 0;
      @(posedge clk);
      #1 in_valid = 0; in_last = 0;
      wait_valid(ok);
      tests++;
      if (!ok || out_data !== 32'd2 || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL bp_next_group: valid=%0b data=%0d ovf=%0b, required 1 2 0", ok, out_data, out_ovf);
      end
      handshake();
   endtask

   task automatic test_gaps();
      bit          ok;
      bit          vseq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] dseq [4] = '{16'd5, 16'd9, 16'd9, 16'd7};
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         in_valid = vseq[i]; in_last = (i == 3); in_sum = dseq[i]; in_carry = 0; in_cout = 0;
         @(posedge clk);
         #1;
      end
      // Keep a junk beat offered while the block is resolving.
      in_valid = 1; in_last = 1; in_sum = 16'd100;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 0; in_last = 0;
      tests++;
      if (!ok || out_data !== 32'd12 || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL gaps_data: valid=%0b data=%0d ovf=%0b, required 1 12 0", ok, out_data, out_ovf);
      end
      handshake();
   endtask

   task automatic test_reset_mid_resolve();
      bit ok;
      bit seen = 1'b0;
      @(negedge clk);
      in_valid = 1; in_last = 1; in_sum = 16'd4; in_carry = 0; in_cout = 0;
      @(posedge clk);
      #1 in_valid = 0; in_last = 0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      tests++;
      if (seen || in_ready !== 1'b1 || out_data !== 32'd0) begin
         fails++;
         $display("FAIL rst_abort: valid_seen=%0b ready=%0b data=%0d, required 0 1 0", seen, in_ready, out_data);
      end
      in_valid = 1; in_last = 1; in_sum = 16'd1;
      @(posedge clk);
      #1 in_valid = 0; in_last = 0;
      wait_valid(ok);
      tests++;
      if (!ok || out_data !== 32'd1 || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL rst_fresh_group: valid=%0b data=%0d ovf=%0b, required 1 1 0", ok, out_data, out_ovf);
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_overflow();
      test_backpressure();
      test_gaps();
      test_reset_mid_resolve();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
